// File: rtl/mips_mc_core_if.sv
// Memory port bundle for mips_mc_core: the core issues fetch/load/store
// requests, the memory answers with read data and a completion ack.
interface mips_mc_core_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS subset core (addu/subu/ori/lui/lw/sw/beq/j/jal/jr) with a
// single shared memory port; one of IF/ID/EX/MEM/WB is active per cycle.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mips_mc_core_if.master mem,
  output logic           wb_en,
  output logic [31:0]    wb_pc,
  output logic [4:0]     wb_reg,
  output logic [31:0]    wb_data,
  output logic           illegal
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] grf_q [32];
  logic [31:0] grf_d [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic        is_legal;
  logic [31:0] pc_plus4, alu_res, pc_ctl, wb_value;
  logic [4:0]  wb_dest;
  logic        req_c;
  logic [31:0] addr_full;
  logic        unused_bits;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign imm26  = ir_q[25:0];

  assign is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw |
                    is_beq | is_j | is_jal;

  assign pc_plus4    = pc_q + 32'd4;
  assign wb_dest     = (is_addu | is_subu) ? rd : rt;
  assign wb_value    = is_lw ? mdr_q : alu_q;
  assign unused_bits = ^{ir_q[10:6], addr_full[1:0]};

  always_comb begin
    alu_res = a_q + imm_q;
    if (is_addu)     alu_res = a_q + b_q;
    else if (is_subu) alu_res = a_q - b_q;
    else if (is_ori)  alu_res = a_q | imm_q;
    else if (is_lui)  alu_res = {imm16, 16'h0000};
  end

  // Control-transfer target; anything that is not a branch/jump falls through.
  always_comb begin
    pc_ctl = pc_plus4;
    if (is_beq && (a_q == b_q)) pc_ctl = pc_plus4 + {imm_q[29:0], 2'b00};
    else if (is_j || is_jal)    pc_ctl = {pc_plus4[31:28], imm26, 2'b00};
    else if (is_jr)             pc_ctl = a_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      grf_q   <= grf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    grf_d   = grf_q;
    case (state_q)
      S_IF: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = S_ID;
        end
      end
      S_ID: begin
        a_d     = grf_q[rs];
        b_d     = grf_q[rt];
        imm_d   = is_ori ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
        state_d = S_EX;
      end
      S_EX: begin
        if (is_addu || is_subu || is_ori || is_lui) begin
          alu_d   = alu_res;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d   = alu_res;
          state_d = S_MEM;
        end else begin
          // Branches, jumps and undecodable words all retire here.
          pc_d    = pc_ctl;
          state_d = S_IF;
          if (is_jal) grf_d[31] = pc_plus4;
        end
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          if (is_sw) begin
            pc_d    = pc_plus4;
            state_d = S_IF;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        grf_d[wb_dest] = wb_value;
        pc_d           = pc_plus4;
        state_d        = S_IF;
      end
      default: state_d = S_IF;
    endcase
    grf_d[0] = '0;
  end

  always_comb begin
    req_c         = 1'b0;
    addr_full     = '0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    wb_en         = 1'b0;
    wb_pc         = pc_q;
    wb_reg        = '0;
    wb_data       = '0;
    illegal       = 1'b0;
    case (state_q)
      S_IF: begin
        req_c     = 1'b1;
        addr_full = pc_q;
      end
      S_ID: illegal = ~is_legal;
      S_EX: begin
        if (is_jal) begin
          wb_en   = 1'b1;
          wb_reg  = 5'd31;
          wb_data = pc_plus4;
        end
      end
      S_MEM: begin
        req_c         = 1'b1;
        addr_full     = alu_q;
        mem.mem_we    = is_sw;
        mem.mem_wdata = is_sw ? b_q : 32'h0;
      end
      S_WB: begin
        wb_en   = (wb_dest != 5'd0);
        wb_reg  = wb_dest;
        wb_data = wb_value;
      end
      default: ;
    endcase
    // Gating with the reset pin drops a pending request immediately on assertion.
    mem.mem_req  = req_c & reset;
    mem.mem_addr = {addr_full[ADDR_W-1:2], 2'b00};
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: small programs in a bench memory,
// expected writebacks/fetches queued up front and popped as the core produces them.
module tb_mips_mc_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en, illegal;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_reg;

  mips_mc_core_if #(.ADDR_W(32)) mif ();

  mips_mc_core #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (mif),
    .wb_en  (wb_en),
    .wb_pc  (wb_pc),
    .wb_reg (wb_reg),
    .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;

  wb_t         sb_q[$];
  logic [31:0] fq[$];
  logic [31:0] imem [0:4095];
  logic [31:0] dmem [0:15];
  int          wait_cnt, data_lat, cyc_cnt, t0;
  int          checks = 0;
  int          errors = 0;
  logic        data_acc;

  // Memory model: data region below 0x3000 gets data_lat wait cycles, fetches are zero-wait.
  always_comb begin
    data_acc      = (mif.mem_addr < 32'h0000_3000);
    mif.mem_ack   = mif.mem_req && (wait_cnt >= (data_acc ? data_lat : 0));
    mif.mem_rdata = data_acc ? dmem[mif.mem_addr[5:2]] : imem[mif.mem_addr[13:2]];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mif.mem_req && !mif.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (reset && mif.mem_req && mif.mem_we && mif.mem_ack && data_acc)
      dmem[mif.mem_addr[5:2]] <= mif.mem_wdata;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) imem[i] = 32'h1000_FFFF;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[13:2]] = word;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    data_lat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    t0    = cyc_cnt;
  endtask

  task automatic wait_wb(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk);
      #1;
      if (wb_en) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    clear_mem();
    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mif.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_req: got %b expected 0", mif.mem_req);
    end
    checks++;
    if (wb_en !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got wb_en=%b illegal=%b expected 0/0", wb_en, illegal);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || mif.mem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL reset_first_fetch: got req=%b we=%b addr=%h expected 1/0/00003000",
               mif.mem_req, mif.mem_we, mif.mem_addr);
    end
  endtask

  task automatic test_ori();
    bit  got;
    wb_t exp;
    clear_mem();
    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    do_reset();
    sb_q.push_back('{32'h3000, 5'd1, 32'h0000_1234});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ori_wb: no wb_en seen, expected pc=%h reg=%0d data=%h", exp.pc, exp.rg, exp.data);
    end else if ({wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL ori_wb: got pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
    checks++;
    if (cyc_cnt - t0 != 3) begin
      errors++;
      $display("FAIL ori_latency: wb after %0d edges expected 3 (4th cycle)", cyc_cnt - t0);
    end
  endtask

  task automatic test_alu();
    bit  got;
    wb_t exp;
    int  t_prev;
    clear_mem();
    put(32'h3000, enc_i(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    put(32'h3004, enc_i(6'h0D, 5'd2, 5'd2, 16'hFFFF));
    put(32'h3008, enc_r(5'd2, 5'd2, 5'd3, 6'h21));
    put(32'h300C, enc_r(5'd3, 5'd2, 5'd5, 6'h23));
    do_reset();
    sb_q.push_back('{32'h3000, 5'd2, 32'hFFFF_0000});
    sb_q.push_back('{32'h3004, 5'd2, 32'hFFFF_FFFF});
    sb_q.push_back('{32'h3008, 5'd3, 32'hFFFF_FFFE});
    sb_q.push_back('{32'h300C, 5'd5, 32'hFFFF_FFFF});
    t_prev = t0;
    for (int k = 0; k < 4; k++) begin
      wait_wb(20, got);
      exp = sb_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL alu_wb%0d: no wb_en seen, expected pc=%h reg=%0d data=%h", k, exp.pc, exp.rg, exp.data);
      end else if ({wb_pc, wb_reg, wb_data} !== exp) begin
        errors++;
        $display("FAIL alu_wb%0d: got pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
                 k, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
      end
      checks++;
      if (cyc_cnt - t_prev != ((k == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL alu_gap%0d: got %0d cycles expected %0d", k, cyc_cnt - t_prev, (k == 0) ? 3 : 4);
      end
      t_prev = cyc_cnt;
    end
  endtask

  task automatic test_mem();
    bit  got;
    wb_t exp;
    int  hold, t_st;
    bit  stable;
    clear_mem();
    put(32'h3000, enc_i(6'h0F, 5'd0, 5'd2, 16'hFFFF));
    put(32'h3004, enc_i(6'h0D, 5'd2, 5'd2, 16'hFFFF));
    put(32'h3008, enc_r(5'd2, 5'd2, 5'd3, 6'h21));
    put(32'h300C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0004));
    put(32'h3010, enc_i(6'h23, 5'd0, 5'd4, 16'h0004));
    do_reset();
    data_lat = 3;
    sb_q.push_back('{32'h3000, 5'd2, 32'hFFFF_0000});
    sb_q.push_back('{32'h3004, 5'd2, 32'hFFFF_FFFF});
    sb_q.push_back('{32'h3008, 5'd3, 32'hFFFF_FFFE});
    for (int k = 0; k < 3; k++) begin
      wait_wb(20, got);
      exp = sb_q.pop_front();
      checks++;
      if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
        errors++;
        $display("FAIL mem_pre_wb%0d: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
                 k, got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
      end
    end
    hold   = 0;
    t_st   = 0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req && mif.mem_we) begin
        hold++;
        t_st = cyc_cnt;
        if (mif.mem_addr !== 32'h4 || mif.mem_wdata !== 32'hFFFF_FFFE) stable = 1'b0;
      end else if (hold > 0) begin
        break;
      end
    end
    data_lat = 0;
    checks++;
    if (hold != 4) begin
      errors++;
      $display("FAIL sw_hold: store held %0d cycles expected 4", hold);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL sw_stable: addr/wdata changed during store, expected addr=4 wdata=fffffffe");
    end
    checks++;
    if (dmem[1] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sw_data: memory word got %h expected fffffffe", dmem[1]);
    end
    sb_q.push_back('{32'h3010, 5'd4, 32'hFFFF_FFFE});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL lw_wb: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
    checks++;
    if (cyc_cnt - t_st != 5) begin
      errors++;
      $display("FAIL lw_latency: got %0d cycles after store expected 5", cyc_cnt - t_st);
    end
  endtask

  task automatic test_branch();
    bit          got;
    wb_t         exp;
    logic [31:0] fexp;
    int          t_prev, nf;
    clear_mem();
    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h0001));
    put(32'h3004, enc_i(6'h04, 5'd1, 5'd0, 16'h0002));
    put(32'h3008, enc_i(6'h0D, 5'd0, 5'd6, 16'h0066));
    put(32'h300C, enc_i(6'h04, 5'd0, 5'd0, 16'h0001));
    put(32'h3010, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    put(32'h3014, enc_i(6'h0D, 5'd0, 5'd8, 16'h0088));
    put(32'h3018, enc_j(6'h02, 26'h0000C04));
    do_reset();
    sb_q.push_back('{32'h3000, 5'd1, 32'h1});
    sb_q.push_back('{32'h3008, 5'd6, 32'h66});
    sb_q.push_back('{32'h3014, 5'd8, 32'h88});
    for (int k = 0; k < 3; k++) begin
      wait_wb(30, got);
      exp = sb_q.pop_front();
      checks++;
      if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
        errors++;
        $display("FAIL branch_wb%0d: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
                 k, got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
      end
    end
    fq = '{32'h3018, 32'h3010, 32'h3010, 32'h3010};
    nf = 0;
    t_prev = cyc_cnt;
    for (int i = 0; i < 40 && fq.size() > 0; i++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req && !mif.mem_we) begin
        fexp = fq.pop_front();
        checks++;
        if (mif.mem_addr !== fexp) begin
          errors++;
          $display("FAIL branch_fetch%0d: got %h expected %h", nf, mif.mem_addr, fexp);
        end
        if (nf > 0) begin
          checks++;
          if (cyc_cnt - t_prev != 3) begin
            errors++;
            $display("FAIL branch_cycles%0d: got %0d expected 3", nf, cyc_cnt - t_prev);
          end
        end
        t_prev = cyc_cnt;
        nf++;
      end
    end
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL branch_fetch_timeout: %0d fetches missing expected 0", fq.size());
      fq.delete();
    end
  endtask

  task automatic test_jump();
    bit          got;
    wb_t         exp;
    logic [31:0] fexp;
    int          wb_cnt, ill_cnt;
    clear_mem();
    put(32'h3000, enc_j(6'h02, 26'h0000C08));
    put(32'h3004, enc_i(6'h0D, 5'd0, 5'd0, 16'h0005));
    put(32'h3008, 32'hFC00_0000);
    put(32'h300C, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    put(32'h3020, enc_j(6'h03, 26'h0000C01));
    put(32'h3024, enc_i(6'h0D, 5'd31, 5'd9, 16'h0000));
    do_reset();
    sb_q.push_back('{32'h3020, 5'd31, 32'h3024});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL jal_wb: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
    checks++;
    if (cyc_cnt - t0 != 5) begin
      errors++;
      $display("FAIL jal_timing: wb after %0d edges expected 5", cyc_cnt - t0);
    end
    fq = '{32'h3004, 32'h3008, 32'h300C, 32'h3024};
    wb_cnt  = 0;
    ill_cnt = 0;
    for (int i = 0; i < 40 && fq.size() > 0; i++) begin
      @(posedge clk);
      #1;
      if (wb_en) wb_cnt++;
      if (illegal) ill_cnt++;
      if (mif.mem_req && !mif.mem_we) begin
        fexp = fq.pop_front();
        checks++;
        if (mif.mem_addr !== fexp) begin
          errors++;
          $display("FAIL jump_fetch: got %h expected %h", mif.mem_addr, fexp);
        end
      end
    end
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL jump_fetch_timeout: %0d fetches missing expected 0", fq.size());
      fq.delete();
    end
    checks++;
    if (wb_cnt != 0) begin
      errors++;
      $display("FAIL r0_write: got %0d wb_en pulses expected 0", wb_cnt);
    end
    checks++;
    if (ill_cnt != 1) begin
      errors++;
      $display("FAIL illegal_pulse: got %0d pulses expected 1", ill_cnt);
    end
    sb_q.push_back('{32'h3024, 5'd9, 32'h3024});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL ra_readback: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
  endtask

  task automatic test_reset_mid();
    bit  got, seen;
    wb_t exp;
    clear_mem();
    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h0055));
    put(32'h3004, enc_i(6'h23, 5'd0, 5'd2, 16'h0008));
    do_reset();
    data_lat = 10;
    sb_q.push_back('{32'h3000, 5'd1, 32'h55});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL midrst_pre_wb: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req && mif.mem_addr == 32'h8) seen = 1'b1;
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (!seen || mif.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async_drop: got seen=%b req=%b expected 1/0", seen, mif.mem_req);
    end
    put(32'h3000, enc_r(5'd1, 5'd0, 5'd5, 6'h21));
    put(32'h3004, 32'h1000_FFFF);
    data_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mif.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_held: got req=%b expected 0", mif.mem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL midrst_refetch: got req=%b addr=%h expected 1/00003000", mif.mem_req, mif.mem_addr);
    end
    sb_q.push_back('{32'h3000, 5'd5, 32'h0});
    wait_wb(20, got);
    exp = sb_q.pop_front();
    checks++;
    if (!got || {wb_pc, wb_reg, wb_data} !== exp) begin
      errors++;
      $display("FAIL midrst_grf_cleared: got en=%b pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
               got, wb_pc, wb_reg, wb_data, exp.pc, exp.rg, exp.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_lat = 0;
    test_reset();
    test_ori();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-002 Parameter ADDR_W, default 32: width of mem_addr; low ADDR_W bits of byte address driven.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 mem_req  output  1  memory request valid.
REQ-006 mem_we  output  1  1 = store, 0 = read; meaningful only while mem_req=1.
REQ-007 mem_addr  output  ADDR_W  byte address, word-aligned.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  read data, valid in cycle mem_ack=1.
REQ-010 mem_ack  input  1  request completion; ignored while mem_req=0.
REQ-011 wb_en  output  1  one-cycle pulse on a register write (rd != 0).
REQ-012 wb_pc / wb_reg / wb_data  output  32/5/32  PC, destination, value of that write.
REQ-013 illegal  output  1  one-cycle pulse when an unsupported instruction is decoded.

Function
REQ-014 Core SHALL be multi-cycle; FSM states IF, ID, EX, MEM, WB, one state active at a time.
REQ-015 Supported: addu, subu, ori, lui, lw, sw, beq, j, jal, jr; any other opcode/func SHALL pulse illegal in ID and execute as nop (PC+4, no write).
REQ-016 IF: mem_req=1, mem_we=0, mem_addr=PC; held stable until mem_ack sampled 1; then IR<=mem_rdata, go ID.
REQ-017 ID: latch A=GRF[rs], B=GRF[rt], ext imm (ori zero-ext, lw/sw/beq sign-ext); go EX.
REQ-018 EX, addu/subu/ori/lui: ALUOut<=result (32-bit, wrap, no overflow trap); go WB.
REQ-019 EX, lw/sw: ALUOut<=A+sext(imm16); go MEM.
REQ-020 EX, beq: PC<=(A==B) ? PC+4+(sext(imm16)<<2) : PC+4; go IF.
REQ-021 EX, j: PC<={PC+4[31:28],imm26,2'b00}; jal additionally writes GRF[31]<=PC+4 with wb pulse; jr: PC<=A; go IF.
REQ-022 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 and mem_wdata=B for sw; hold until mem_ack; sw then PC<=PC+4, go IF; lw latches mem_rdata into MDR, go WB.
REQ-023 WB: GRF[dest]<=value (rd for R-type, rt for ori/lui/lw), PC<=PC+4, go IF.
REQ-024 Writes to $0 SHALL be discarded and SHALL NOT pulse wb_en; GRF[0] reads 0.
REQ-025 Cycle counts with zero-wait ack: ALU 4, lw 5, sw 4, branch/jump 3.
REQ-026 mem_ack in the same cycle mem_req rises SHALL complete the access that edge; N low ack cycles add N cycles.
REQ-027 mem_addr[1:0] SHALL always be 2'b00 for valid programs; unaligned addresses are truncated, not trapped.
REQ-028 wb_pc SHALL be the PC of the instruction performing the write.

Reset
REQ-029 While reset=0: state=IF, PC=RESET_PC, all 32 GRF entries 0, IR/A/B/ALUOut/MDR 0, mem_req=0, wb_en=0, illegal=0.
REQ-030 Reset asserted mid-access SHALL drop mem_req asynchronously; pending ack ignored; first request after release is fetch at RESET_PC on the first clk edge after reset=1.

Verification
REQ-031 Release reset, memory ack zero-wait, word 0x3000 = ori $1,$0,0x1234 -> cycle 4 wb_en, wb_reg=1, wb_data=0x0000_1234, wb_pc=0x3000.
REQ-032 lui $2,0xFFFF; ori $2,$2,0xFFFF; addu $3,$2,$2 -> wb_data 0xFFFF_FFFE for $3 (wrap).
REQ-033 sw $3,4($0) with ack delayed 3 cycles -> mem_we=1, mem_addr=4, mem_wdata held stable 4 cycles; then lw $4,4($0) -> wb_data equals stored value.
REQ-034 beq $0,$0,-1 at 0x3010 -> next fetch 0x3010 (loop); beq $1,$0,+2 with $1!=0 -> fetch PC+4.
REQ-035 jal 0x0C01 at 0x3020 -> GRF[31]=0x3024, next fetch 0x0000_3004; jr $31 -> fetch 0x3024; ori $0,$0,5 -> no wb_en; opcode 0x3F -> illegal pulse, fetch PC+4.
REQ-036 Assert reset during MEM wait -> mem_req=0 immediately; after release, first mem_addr=RESET_PC, registers read 0.
